axi4_lite_arbiter: RTL and testbench
====================================

Name: axi4_lite_arbiter

Overview:
- Two-to-one AXI4-Lite arbiter between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write).
- Drives the single shared AXI4-Lite port toward memory or crossbar. Sits between the IFU/LSU bus masters and the downstream slave.
- Grants one whole transaction at a time: grant is held until the final response handshake (R for reads, B for writes).
- Arbitration is round-robin; only one transaction is outstanding system-wide.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
MASK_WIDTH, 4, write strobe width (DATA_WIDTH/8)
RESP_WIDTH, 2, response code width

Ports:
iClock  in  1  clock, all logic on rising edge
iReset  in  1  synchronous reset, active-high
pIFU_ar_valid in 1 / pIFU_ar_ready out 1 / pIFU_ar_bits_addr in ADDR_WIDTH: IFU read address
pIFU_r_valid out 1 / pIFU_r_ready in 1 / pIFU_r_bits_data out DATA_WIDTH / pIFU_r_bits_resp out RESP_WIDTH: IFU read data
pLSU_ar_* / pLSU_r_*: same as the IFU channels, LSU side
pLSU_aw_valid in 1 / pLSU_aw_ready out 1 / pLSU_aw_bits_addr in ADDR_WIDTH: LSU write address
pLSU_w_valid in 1 / pLSU_w_ready out 1 / pLSU_w_bits_data in DATA_WIDTH / pLSU_w_bits_strb in MASK_WIDTH: LSU write data
pLSU_b_valid out 1 / pLSU_b_ready in 1 / pLSU_b_bits_resp out RESP_WIDTH: LSU write response
pAXI4M_ar_*, pAXI4M_r_*, pAXI4M_aw_*, pAXI4M_w_*, pAXI4M_b_*: downstream master port, same widths; directions mirror the LSU side (valid/addr/data out, ready in for AR/AW/W; valid/data/resp in, ready out for R/B)

Behaviour:
- States: IDLE, IFU_RD, LSU_RD, LSU_WR. State register plus 1-bit last-grant register (0=IFU, 1=LSU).
- Reset (iReset=1 at a clock edge):
  - state becomes IDLE; last-grant becomes LSU, so IFU wins the first tie.
  - Every valid and ready output is 0 from the cycle after the reset edge. Data, addr and resp outputs are don't-care but driven 0 while not granted.
  - An in-flight transaction is abandoned without draining.
- IDLE request set: IFU = pIFU_ar_valid; LSU = pLSU_ar_valid | pLSU_aw_valid.
  - Exactly one requester: grant it.
  - Both requesting: grant the one not equal to last-grant.
  - LSU granted with both ar_valid and aw_valid high: read wins.
  - Grant takes effect the next cycle (state register). No combinational path from request to pAXI4M_*_valid in IDLE.
  - Last-grant updates on entering a granted state.
- Granted state, routing:
  - Channels of the owner are connected combinationally to pAXI4M_* in both directions (valid, ready, payload).
  - Non-owner ready outputs are forced 0; non-owner valid outputs are 0.
  - Unused master channels: valid 0; pAXI4M_r_ready/b_ready 0 when not routed.
- Ownership ends:
  - IFU_RD and LSU_RD return to IDLE on the cycle after pAXI4M_r_valid & pAXI4M_r_ready.
  - LSU_WR returns to IDLE on the cycle after pAXI4M_b_valid & pAXI4M_b_ready.
  - AR, AW and W handshakes do not change state.
- LSU_WR: AW and W are routed independently; either order or simultaneous handshake is legal.
- Back-to-back: no bubble beyond the one IDLE cycle. Under continuous requests from both, grants strictly alternate.
- Requester valid dropping while waiting in IDLE (protocol violation): no grant. Dropping mid-grant is not checked.
- A new request arriving on the response-handshake cycle is evaluated in the following IDLE cycle.
- Latency: one added cycle on the address phase only; response paths are zero-latency.

Decomposition:
- Shared package:
  - width macros ADDR_WIDTH/DATA_WIDTH/MASK_WIDTH/RESP_WIDTH from the existing Config.v;
  - state encoding constants STATE_ARB_IDLE=2'b00, STATE_ARB_IFU_RD=2'b01, STATE_ARB_LSU_RD=2'b10, STATE_ARB_LSU_WR=2'b11;
  - response codes OKAY=2'b00, SLVERR=2'b10.
- One natural sub-module: axi4_lite_arb_rr. A 2-input round-robin picker holding the last-grant flop, with inputs req[1:0] and update, and output gnt[1:0].
- Channel muxing stays in the top.

Test Plan:
- Reset then IFU only:
  - Stimulus: IFU ar_valid with addr 0x80000000; slave returns data 0xDEADBEEF, resp OKAY.
  - Required: pAXI4M_ar_valid high 1 cycle after the request; pIFU_r_valid gets 0xDEADBEEF; back to IDLE 1 cycle after the R handshake.
- Simultaneous IFU read and LSU read after reset:
  - Required: IFU served first, then LSU.
  - Repeat continuously for 8 transactions: grants alternate IFU, LSU, IFU, and so on.
- LSU write:
  - Stimulus: addr 0x80001000, data 0x12345678, strb 4'b0011; slave accepts W two cycles before AW.
  - Required: the master port reflects the same values; pLSU_b_valid with resp OKAY; IFU ar_ready stays 0 throughout.
- LSU ar_valid and aw_valid together:
  - Required: read granted first; write granted only after the read's R handshake plus one IDLE cycle (when IFU is idle).
- Reset mid-transaction:
  - Stimulus: assert iReset during LSU_WR after the AW handshake.
  - Required: all valid/ready outputs 0 on the next cycle; the next IFU request is served normally.
- Slave SLVERR:
  - Stimulus: slave returns resp 2'b10 with back-pressure (pIFU_r_ready low for 3 cycles).
  - Required: resp passed through unchanged; the state holds IFU_RD until the R handshake.

Source files
------------

// File: rtl/axi4_lite_arbiter_pkg.sv
// Shared widths, arbiter state encoding and AXI response codes for the
// IFU/LSU AXI4-Lite arbiter.
package axi4_lite_arbiter_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int RESP_WIDTH = 2;

  typedef enum logic [1:0] {
    STATE_ARB_IDLE   = 2'b00,
    STATE_ARB_IFU_RD = 2'b01,
    STATE_ARB_LSU_RD = 2'b10,
    STATE_ARB_LSU_WR = 2'b11
  } arb_state_t;

  localparam logic [RESP_WIDTH-1:0] OKAY   = 2'b00;
  localparam logic [RESP_WIDTH-1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_arb_rr.sv
// Two-input round-robin picker. Bit 0 is the IFU, bit 1 the LSU; the
// last-grant flop starts at LSU so the IFU wins the first tie.
module axi4_lite_arb_rr
  import axi4_lite_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// Two-to-one AXI4-Lite arbiter: IFU (read-only) and LSU (read/write) share one
// downstream port, one whole transaction at a time, round-robin between them.
module axi4_lite_arbiter #(
  parameter int ADDR_WIDTH = axi4_lite_arbiter_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi4_lite_arbiter_pkg::DATA_WIDTH,
  parameter int MASK_WIDTH = axi4_lite_arbiter_pkg::MASK_WIDTH,
  parameter int RESP_WIDTH = axi4_lite_arbiter_pkg::RESP_WIDTH
) (
  input  logic                  iClock,
  input  logic                  iReset,
  // IFU read channels
  input  logic                  pIFU_ar_valid,
  output logic                  pIFU_ar_ready,
  input  logic [ADDR_WIDTH-1:0] pIFU_ar_bits_addr,
  output logic                  pIFU_r_valid,
  input  logic                  pIFU_r_ready,
  output logic [DATA_WIDTH-1:0] pIFU_r_bits_data,
  output logic [RESP_WIDTH-1:0] pIFU_r_bits_resp,
  // LSU read channels
  input  logic                  pLSU_ar_valid,
  output logic                  pLSU_ar_ready,
  input  logic [ADDR_WIDTH-1:0] pLSU_ar_bits_addr,
  output logic                  pLSU_r_valid,
  input  logic                  pLSU_r_ready,
  output logic [DATA_WIDTH-1:0] pLSU_r_bits_data,
  output logic [RESP_WIDTH-1:0] pLSU_r_bits_resp,
  // LSU write channels
  input  logic                  pLSU_aw_valid,
  output logic                  pLSU_aw_ready,
  input  logic [ADDR_WIDTH-1:0] pLSU_aw_bits_addr,
  input  logic                  pLSU_w_valid,
  output logic                  pLSU_w_ready,
  input  logic [DATA_WIDTH-1:0] pLSU_w_bits_data,
  input  logic [MASK_WIDTH-1:0] pLSU_w_bits_strb,
  output logic                  pLSU_b_valid,
  input  logic                  pLSU_b_ready,
  output logic [RESP_WIDTH-1:0] pLSU_b_bits_resp,
  // Downstream master port
  output logic                  pAXI4M_ar_valid,
  input  logic                  pAXI4M_ar_ready,
  output logic [ADDR_WIDTH-1:0] pAXI4M_ar_bits_addr,
  input  logic                  pAXI4M_r_valid,
  output logic                  pAXI4M_r_ready,
  input  logic [DATA_WIDTH-1:0] pAXI4M_r_bits_data,
  input  logic [RESP_WIDTH-1:0] pAXI4M_r_bits_resp,
  output logic                  pAXI4M_aw_valid,
  input  logic                  pAXI4M_aw_ready,
  output logic [ADDR_WIDTH-1:0] pAXI4M_aw_bits_addr,
  output logic                  pAXI4M_w_valid,
  input  logic                  pAXI4M_w_ready,
  output logic [DATA_WIDTH-1:0] pAXI4M_w_bits_data,
  output logic [MASK_WIDTH-1:0] pAXI4M_w_bits_strb,
  input  logic                  pAXI4M_b_valid,
  output logic                  pAXI4M_b_ready,
  input  logic [RESP_WIDTH-1:0] pAXI4M_b_bits_resp
);

  import axi4_lite_arbiter_pkg::*;

  arb_state_t state_q;
  arb_state_t state_d;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       update;

  assign req    = {pLSU_ar_valid | pLSU_aw_valid, pIFU_ar_valid};
  assign update = (state_q == STATE_ARB_IDLE) && (req != 2'b00);

  axi4_lite_arb_rr u_rr (
    .clk    (iClock),
    .rst    (iReset),
    .req    (req),
    .update (update),
    .gnt    (gnt)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= STATE_ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ownership ends only on the final response handshake of the transaction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_ARB_IDLE: begin
        if (gnt[0]) begin
          state_d = STATE_ARB_IFU_RD;
        end else if (gnt[1]) begin
          state_d = pLSU_ar_valid ? STATE_ARB_LSU_RD : STATE_ARB_LSU_WR;
        end
      end
      STATE_ARB_IFU_RD, STATE_ARB_LSU_RD: begin
        if (pAXI4M_r_valid && pAXI4M_r_ready) state_d = STATE_ARB_IDLE;
      end
      STATE_ARB_LSU_WR: begin
        if (pAXI4M_b_valid && pAXI4M_b_ready) state_d = STATE_ARB_IDLE;
      end
      default: state_d = STATE_ARB_IDLE;
    endcase
  end

  always_comb begin
    pIFU_ar_ready       = 1'b0;
    pIFU_r_valid        = 1'b0;
    pIFU_r_bits_data    = '0;
    pIFU_r_bits_resp    = '0;
    pLSU_ar_ready       = 1'b0;
    pLSU_r_valid        = 1'b0;
    pLSU_r_bits_data    = '0;
    pLSU_r_bits_resp    = '0;
    pLSU_aw_ready       = 1'b0;
    pLSU_w_ready        = 1'b0;
    pLSU_b_valid        = 1'b0;
    pLSU_b_bits_resp    = '0;
    pAXI4M_ar_valid     = 1'b0;
    pAXI4M_ar_bits_addr = '0;
    pAXI4M_r_ready      = 1'b0;
    pAXI4M_aw_valid     = 1'b0;
    pAXI4M_aw_bits_addr = '0;
    pAXI4M_w_valid      = 1'b0;
    pAXI4M_w_bits_data  = '0;
    pAXI4M_w_bits_strb  = '0;
    pAXI4M_b_ready      = 1'b0;
    case (state_q)
      STATE_ARB_IFU_RD: begin
        pAXI4M_ar_valid     = pIFU_ar_valid;
        pAXI4M_ar_bits_addr = pIFU_ar_bits_addr;
        pIFU_ar_ready       = pAXI4M_ar_ready;
        pIFU_r_valid        = pAXI4M_r_valid;
        pIFU_r_bits_data    = pAXI4M_r_bits_data;
        pIFU_r_bits_resp    = pAXI4M_r_bits_resp;
        pAXI4M_r_ready      = pIFU_r_ready;
      end
      STATE_ARB_LSU_RD: begin
        pAXI4M_ar_valid     = pLSU_ar_valid;
        pAXI4M_ar_bits_addr = pLSU_ar_bits_addr;
        pLSU_ar_ready       = pAXI4M_ar_ready;
        pLSU_r_valid        = pAXI4M_r_valid;
        pLSU_r_bits_data    = pAXI4M_r_bits_data;
        pLSU_r_bits_resp    = pAXI4M_r_bits_resp;
        pAXI4M_r_ready      = pLSU_r_ready;
      end
      STATE_ARB_LSU_WR: begin
        pAXI4M_aw_valid     = pLSU_aw_valid;
        pAXI4M_aw_bits_addr = pLSU_aw_bits_addr;
        pLSU_aw_ready       = pAXI4M_aw_ready;
        pAXI4M_w_valid      = pLSU_w_valid;
        pAXI4M_w_bits_data  = pLSU_w_bits_data;
        pAXI4M_w_bits_strb  = pLSU_w_bits_strb;
        pLSU_w_ready        = pAXI4M_w_ready;
        pLSU_b_valid        = pAXI4M_b_valid;
        pLSU_b_bits_resp    = pAXI4M_b_bits_resp;
        pAXI4M_b_ready      = pLSU_b_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench for the IFU/LSU AXI4-Lite arbiter with grant and response
// scoreboards.
module tb_axi4_lite_arbiter;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        pIFU_ar_valid = 1'b0, pIFU_ar_ready;
  logic [31:0] pIFU_ar_bits_addr = '0;
  logic        pIFU_r_valid, pIFU_r_ready = 1'b1;
  logic [31:0] pIFU_r_bits_data;
  logic [1:0]  pIFU_r_bits_resp;
  logic        pLSU_ar_valid = 1'b0, pLSU_ar_ready;
  logic [31:0] pLSU_ar_bits_addr = '0;
  logic        pLSU_r_valid, pLSU_r_ready = 1'b1;
  logic [31:0] pLSU_r_bits_data;
  logic [1:0]  pLSU_r_bits_resp;
  logic        pLSU_aw_valid = 1'b0, pLSU_aw_ready;
  logic [31:0] pLSU_aw_bits_addr = '0;
  logic        pLSU_w_valid = 1'b0, pLSU_w_ready;
  logic [31:0] pLSU_w_bits_data = '0;
  logic [3:0]  pLSU_w_bits_strb = '0;
  logic        pLSU_b_valid, pLSU_b_ready = 1'b1;
  logic [1:0]  pLSU_b_bits_resp;
  logic        pAXI4M_ar_valid, pAXI4M_ar_ready = 1'b0;
  logic [31:0] pAXI4M_ar_bits_addr;
  logic        pAXI4M_r_valid = 1'b0, pAXI4M_r_ready;
  logic [31:0] pAXI4M_r_bits_data = '0;
  logic [1:0]  pAXI4M_r_bits_resp = '0;
  logic        pAXI4M_aw_valid, pAXI4M_aw_ready = 1'b0;
  logic [31:0] pAXI4M_aw_bits_addr;
  logic        pAXI4M_w_valid, pAXI4M_w_ready = 1'b0;
  logic [31:0] pAXI4M_w_bits_data;
  logic [3:0]  pAXI4M_w_bits_strb;
  logic        pAXI4M_b_valid = 1'b0, pAXI4M_b_ready;
  logic [1:0]  pAXI4M_b_bits_resp = '0;

  axi4_lite_arbiter dut (
    .iClock(iClock), .iReset(iReset),
    .pIFU_ar_valid(pIFU_ar_valid), .pIFU_ar_ready(pIFU_ar_ready), .pIFU_ar_bits_addr(pIFU_ar_bits_addr),
    .pIFU_r_valid(pIFU_r_valid), .pIFU_r_ready(pIFU_r_ready), .pIFU_r_bits_data(pIFU_r_bits_data),
    .pIFU_r_bits_resp(pIFU_r_bits_resp),
    .pLSU_ar_valid(pLSU_ar_valid), .pLSU_ar_ready(pLSU_ar_ready), .pLSU_ar_bits_addr(pLSU_ar_bits_addr),
    .pLSU_r_valid(pLSU_r_valid), .pLSU_r_ready(pLSU_r_ready), .pLSU_r_bits_data(pLSU_r_bits_data),
    .pLSU_r_bits_resp(pLSU_r_bits_resp),
    .pLSU_aw_valid(pLSU_aw_valid), .pLSU_aw_ready(pLSU_aw_ready), .pLSU_aw_bits_addr(pLSU_aw_bits_addr),
    .pLSU_w_valid(pLSU_w_valid), .pLSU_w_ready(pLSU_w_ready), .pLSU_w_bits_data(pLSU_w_bits_data),
    .pLSU_w_bits_strb(pLSU_w_bits_strb),
    .pLSU_b_valid(pLSU_b_valid), .pLSU_b_ready(pLSU_b_ready), .pLSU_b_bits_resp(pLSU_b_bits_resp),
    .pAXI4M_ar_valid(pAXI4M_ar_valid), .pAXI4M_ar_ready(pAXI4M_ar_ready),
    .pAXI4M_ar_bits_addr(pAXI4M_ar_bits_addr),
    .pAXI4M_r_valid(pAXI4M_r_valid), .pAXI4M_r_ready(pAXI4M_r_ready),
    .pAXI4M_r_bits_data(pAXI4M_r_bits_data), .pAXI4M_r_bits_resp(pAXI4M_r_bits_resp),
    .pAXI4M_aw_valid(pAXI4M_aw_valid), .pAXI4M_aw_ready(pAXI4M_aw_ready),
    .pAXI4M_aw_bits_addr(pAXI4M_aw_bits_addr),
    .pAXI4M_w_valid(pAXI4M_w_valid), .pAXI4M_w_ready(pAXI4M_w_ready),
    .pAXI4M_w_bits_data(pAXI4M_w_bits_data), .pAXI4M_w_bits_strb(pAXI4M_w_bits_strb),
    .pAXI4M_b_valid(pAXI4M_b_valid), .pAXI4M_b_ready(pAXI4M_b_ready),
    .pAXI4M_b_bits_resp(pAXI4M_b_bits_resp)
  );

  always #5 iClock = ~iClock;

  typedef struct { logic owner; logic [31:0] addr; } gnt_t;
  typedef struct { logic owner; logic [31:0] data; logic [1:0] resp; } rsp_t;
  gnt_t gq[$];
  rsp_t rq[$];
  int checks = 0;
  int errors = 0;
  int last_wait = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  function automatic logic [11:0] vr_outs();
    return {pIFU_ar_ready, pIFU_r_valid, pLSU_ar_ready, pLSU_r_valid, pLSU_aw_ready, pLSU_w_ready,
            pLSU_b_valid, pAXI4M_ar_valid, pAXI4M_r_ready, pAXI4M_aw_valid, pAXI4M_w_valid,
            pAXI4M_b_ready};
  endfunction

  task automatic serve_read(input logic [31:0] rdata, input logic [1:0] rresp, input int rwait);
    gnt_t g;
    rsp_t e;
    int n = 0;
    g = '{owner: 1'b0, addr: 32'h0};
    while (!pAXI4M_ar_valid && n < 10) begin tick(); n++; end
    last_wait = n;
    chk("ar_valid_wait", {63'd0, pAXI4M_ar_valid}, 64'd1);
    if (gq.size() > 0) g = gq.pop_front();
    pAXI4M_ar_ready = 1'b1;
    #1;
    chk("ar_owner", {63'd0, pLSU_ar_ready}, {63'd0, g.owner});
    chk("ar_nonowner", {63'd0, pIFU_ar_ready}, {63'd0, !g.owner});
    chk("ar_addr", {32'd0, pAXI4M_ar_bits_addr}, {32'd0, g.addr});
    tick();
    pAXI4M_ar_ready = 1'b0;
    pAXI4M_r_valid = 1'b1;
    pAXI4M_r_bits_data = rdata;
    pAXI4M_r_bits_resp = rresp;
    rq.push_back('{owner: g.owner, data: rdata, resp: rresp});
    if (rwait > 0) begin pIFU_r_ready = 1'b0; pLSU_r_ready = 1'b0; end
    #1;
    for (int i = 0; i < rwait; i++) begin
      chk("bp_r_valid", {63'd0, (g.owner ? pLSU_r_valid : pIFU_r_valid)}, 64'd1);
      chk("bp_r_resp", {62'd0, (g.owner ? pLSU_r_bits_resp : pIFU_r_bits_resp)}, {62'd0, rresp});
      chk("bp_m_r_ready", {63'd0, pAXI4M_r_ready}, 64'd0);
      tick();
    end
    pIFU_r_ready = 1'b1;
    pLSU_r_ready = 1'b1;
    #1;
    e = rq.pop_front();
    chk("r_valid", {63'd0, (e.owner ? pLSU_r_valid : pIFU_r_valid)}, 64'd1);
    chk("r_other_valid", {63'd0, (e.owner ? pIFU_r_valid : pLSU_r_valid)}, 64'd0);
    chk("r_data", {32'd0, (e.owner ? pLSU_r_bits_data : pIFU_r_bits_data)}, {32'd0, e.data});
    chk("r_resp", {62'd0, (e.owner ? pLSU_r_bits_resp : pIFU_r_bits_resp)}, {62'd0, e.resp});
    chk("m_r_ready", {63'd0, pAXI4M_r_ready}, 64'd1);
    tick();
    pAXI4M_r_valid = 1'b0;
    #1;
    chk("idle_after_r", {52'd0, vr_outs()}, 64'd0);
  endtask

  task automatic serve_write(input logic [31:0] wdata, input logic [3:0] wstrb, input bit w_lead);
    gnt_t g;
    rsp_t e;
    int n = 0;
    g = '{owner: 1'b1, addr: 32'h0};
    while (!pAXI4M_aw_valid && n < 10) begin tick(); n++; end
    last_wait = n;
    chk("aw_valid_wait", {63'd0, pAXI4M_aw_valid}, 64'd1);
    if (gq.size() > 0) g = gq.pop_front();
    chk("wr_owner_lsu", {63'd0, g.owner}, 64'd1);
    chk("aw_addr", {32'd0, pAXI4M_aw_bits_addr}, {32'd0, g.addr});
    chk("w_valid", {63'd0, pAXI4M_w_valid}, 64'd1);
    chk("w_data", {32'd0, pAXI4M_w_bits_data}, {32'd0, wdata});
    chk("w_strb", {60'd0, pAXI4M_w_bits_strb}, {60'd0, wstrb});
    chk("wr_m_ar_valid", {63'd0, pAXI4M_ar_valid}, 64'd0);
    if (w_lead) begin
      pAXI4M_w_ready = 1'b1;
      #1;
      chk("w_ready_first", {62'd0, pLSU_w_ready, pLSU_aw_ready}, 64'd2);
      chk("wr_ifu_ar_ready", {63'd0, pIFU_ar_ready}, 64'd0);
      tick();
      pLSU_w_valid = 1'b0;
      pAXI4M_w_ready = 1'b0;
      #1;
      chk("w_valid_drop", {63'd0, pAXI4M_w_valid}, 64'd0);
      chk("wr_ifu_ar_ready", {63'd0, pIFU_ar_ready}, 64'd0);
      tick();
      pAXI4M_aw_ready = 1'b1;
      #1;
      chk("aw_ready_second", {62'd0, pLSU_w_ready, pLSU_aw_ready}, 64'd1);
    end else begin
      pAXI4M_aw_ready = 1'b1;
      pAXI4M_w_ready = 1'b1;
      #1;
      chk("aw_w_ready", {62'd0, pLSU_w_ready, pLSU_aw_ready}, 64'd3);
    end
    chk("wr_ifu_ar_ready", {63'd0, pIFU_ar_ready}, 64'd0);
    tick();
    pLSU_aw_valid = 1'b0;
    pLSU_w_valid = 1'b0;
    pAXI4M_aw_ready = 1'b0;
    pAXI4M_w_ready = 1'b0;
    pAXI4M_b_valid = 1'b1;
    pAXI4M_b_bits_resp = 2'b00;
    rq.push_back('{owner: 1'b1, data: 32'h0, resp: 2'b00});
    #1;
    e = rq.pop_front();
    chk("b_valid", {63'd0, pLSU_b_valid}, 64'd1);
    chk("b_resp", {62'd0, pLSU_b_bits_resp}, {62'd0, e.resp});
    chk("m_b_ready", {63'd0, pAXI4M_b_ready}, 64'd1);
    chk("wr_ifu_ar_ready", {63'd0, pIFU_ar_ready}, 64'd0);
    tick();
    pAXI4M_b_valid = 1'b0;
    #1;
    chk("idle_after_b", {52'd0, vr_outs()}, 64'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset_outs", {52'd0, vr_outs()}, 64'd0);
    chk("reset_addr", {32'd0, pAXI4M_ar_bits_addr}, 64'd0);
    iReset = 1'b0;

    // IFU only: one cycle of address latency
    tick();
    pIFU_ar_valid = 1'b1;
    pIFU_ar_bits_addr = 32'h8000_0000;
    gq.push_back('{owner: 1'b0, addr: 32'h8000_0000});
    #1;
    chk("no_comb_grant", {63'd0, pAXI4M_ar_valid}, 64'd0);
    tick();
    chk("ar_one_cycle", {63'd0, pAXI4M_ar_valid}, 64'd1);
    serve_read(32'hDEAD_BEEF, 2'b00, 0);
    pIFU_ar_valid = 1'b0;
    tick();
    chk("no_regrant", {63'd0, pAXI4M_ar_valid}, 64'd0);

    // Reset, then continuous simultaneous reads alternate starting with IFU
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    pIFU_ar_valid = 1'b1;
    pIFU_ar_bits_addr = 32'h8000_0100;
    pLSU_ar_valid = 1'b1;
    pLSU_ar_bits_addr = 32'h8000_0200;
    for (int i = 0; i < 8; i++) begin
      gq.push_back('{owner: i[0], addr: (i[0] ? 32'h8000_0200 : 32'h8000_0100)});
    end
    for (int i = 0; i < 8; i++) begin
      serve_read(32'hA000_0000 + i, 2'b00, 0);
      chk("alt_gap", 64'(last_wait), 64'd1);
    end
    pIFU_ar_valid = 1'b0;
    pLSU_ar_valid = 1'b0;

    // LSU write, W accepted two cycles before AW; IFU requests meanwhile
    tick();
    pLSU_aw_valid = 1'b1;
    pLSU_aw_bits_addr = 32'h8000_1000;
    pLSU_w_valid = 1'b1;
    pLSU_w_bits_data = 32'h1234_5678;
    pLSU_w_bits_strb = 4'b0011;
    gq.push_back('{owner: 1'b1, addr: 32'h8000_1000});
    gq.push_back('{owner: 1'b0, addr: 32'h8000_0300});
    tick();
    pIFU_ar_valid = 1'b1;
    pIFU_ar_bits_addr = 32'h8000_0300;
    pAXI4M_ar_ready = 1'b1;
    serve_write(32'h1234_5678, 4'b0011, 1'b1);
    serve_read(32'h0BAD_F00D, 2'b00, 0);
    pIFU_ar_valid = 1'b0;

    // LSU read and write together: read first, write after one IDLE cycle
    tick();
    pLSU_ar_valid = 1'b1;
    pLSU_ar_bits_addr = 32'h8000_2000;
    pLSU_aw_valid = 1'b1;
    pLSU_aw_bits_addr = 32'h8000_2004;
    pLSU_w_valid = 1'b1;
    pLSU_w_bits_data = 32'hCAFE_0001;
    pLSU_w_bits_strb = 4'b1111;
    gq.push_back('{owner: 1'b1, addr: 32'h8000_2000});
    gq.push_back('{owner: 1'b1, addr: 32'h8000_2004});
    serve_read(32'h5555_AAAA, 2'b00, 0);
    pLSU_ar_valid = 1'b0;
    #1;
    chk("wr_waits_idle", {63'd0, pAXI4M_aw_valid}, 64'd0);
    serve_write(32'hCAFE_0001, 4'b1111, 1'b0);
    chk("rd_wr_gap", 64'(last_wait), 64'd1);

    // Reset during LSU_WR after the AW handshake
    tick();
    pLSU_aw_valid = 1'b1;
    pLSU_aw_bits_addr = 32'h8000_3000;
    pLSU_w_valid = 1'b1;
    tick();
    chk("rst_wr_granted", {63'd0, pAXI4M_aw_valid}, 64'd1);
    pAXI4M_aw_ready = 1'b1;
    tick();
    iReset = 1'b1;
    pAXI4M_w_ready = 1'b1;
    pAXI4M_b_valid = 1'b1;
    pAXI4M_r_valid = 1'b1;
    pAXI4M_ar_ready = 1'b1;
    pIFU_ar_valid = 1'b1;
    pIFU_ar_bits_addr = 32'h8000_0400;
    tick();
    chk("rst_mid_outs", {52'd0, vr_outs()}, 64'd0);
    chk("rst_mid_awaddr", {32'd0, pAXI4M_aw_bits_addr}, 64'd0);
    iReset = 1'b0;
    pLSU_aw_valid = 1'b0;
    pLSU_w_valid = 1'b0;
    pAXI4M_aw_ready = 1'b0;
    pAXI4M_w_ready = 1'b0;
    pAXI4M_b_valid = 1'b0;
    pAXI4M_r_valid = 1'b0;
    pAXI4M_ar_ready = 1'b0;
    gq.push_back('{owner: 1'b0, addr: 32'h8000_0400});
    serve_read(32'h7777_0000, 2'b00, 0);
    pIFU_ar_valid = 1'b0;

    // SLVERR passed through under IFU back-pressure
    tick();
    pIFU_ar_valid = 1'b1;
    pIFU_ar_bits_addr = 32'h8000_0500;
    gq.push_back('{owner: 1'b0, addr: 32'h8000_0500});
    serve_read(32'h0000_0000, 2'b10, 3);
    pIFU_ar_valid = 1'b0;
    tick();
    chk("scoreboards_empty", 64'(gq.size() + rq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
